clock_mode_controller: RTL and testbench
========================================

Name: clock_mode_controller

Overview:
- Top-level sequencer for the digital clock.
- Turns single-cycle button pulses into the 2-bit `phase` select, the field-edit sequence, blink enables and load/run/clear strobes.
- Drives the clock, countdown, stopwatch and user-input datapaths, plus the 7-segment blink masks.
- Also owns countdown-expiry alarm handling.

Parameters:
- BLINK_HALF, 25_000_000: clk cycles per blink half-period (on/off toggle interval).
- ALARM_CYCLES, 500_000_000: max alarm duration in clk cycles before auto-clear.
- EDIT_TIMEOUT, 1_000_000_000: idle cycles before edit auto-cancel; used only with EDIT_TIMEOUT_EN.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- btn_mode  in  1  one-cycle pulse: next mode, or cancel edit.
- btn_edit  in  1  one-cycle pulse: enter edit / advance field / commit; stopwatch clear.
- btn_start  in  1  one-cycle pulse: countdown start/pause, stopwatch run/stop.
- cd_zero  in  1  level: countdown value == 0.
- phase  out  2  00 user input, 01 countdown, 10 clock, 11 stopwatch.
- edit_field  out  2  00 none, 01 sec, 10 min, 11 hour.
- blink_sec, blink_min, blink_hour  out  1 each  blank mask for the display digit pairs.
- load_clk  out  1  one-cycle pulse: commit user value to clock.
- load_cd  out  1  one-cycle pulse: commit user value to countdown.
- cd_run  out  1  level: countdown counting.
- sw_run  out  1  level: stopwatch counting.
- sw_clear  out  1  one-cycle pulse: clear stopwatch.
- alarm  out  1  level: countdown expired.

Behaviour:
- Interface fixed: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - state=CLOCK, phase=10, edit_field=00.
  - All pulses, blink bits, cd_run, sw_run and alarm = 0.
  - Blink, alarm and timeout counters = 0.
- All outputs are registered; each responds one cycle after the causing pulse.
- States and phase encoding:
  - CLOCK (10), CLK_EDIT (00), CD_IDLE (01), CD_EDIT (00), CD_RUN (01), CD_ALARM (01), SW (11).
- btn_mode:
  - CLOCK -> CD_IDLE -> SW -> CLOCK.
  - Ignored in CD_RUN (countdown must be paused first).
  - In CD_ALARM: acknowledge.
  - In either edit state: cancel, return to the parent state, no load pulse.
- btn_edit in CLOCK or CD_IDLE:
  - Enter the matching edit state with edit_field=01.
  - Further btn_edit: 01->10->11.
  - btn_edit at 11 commits: one-cycle load_clk (CLK_EDIT) or load_cd (CD_EDIT), return to parent, edit_field=00.
- btn_start:
  - CD_IDLE -> CD_RUN only if cd_zero==0; otherwise ignored.
  - CD_RUN -> CD_IDLE (pause).
  - In SW: toggles sw_run.
  - Ignored in edit states.
- btn_edit in SW: one-cycle sw_clear only when sw_run==0; ignored while running.
- cd_run = 1 exactly in CD_RUN.
- sw_run persists across mode changes; the stopwatch runs in the background.
- Expiry: CD_RUN with cd_zero==1 -> CD_ALARM.
  - cd_run drops and alarm=1 on the same edge.
  - Alarm counter counts ALARM_CYCLES.
  - Any button or counter terminal -> CD_IDLE, alarm=0.
- Blink:
  - Free-running counter 0..BLINK_HALF-1; toggles blink_phase at wrap.
  - Counter and blink_phase reset to 0 on every edit-state entry, so the first half-period is always shown.
  - blink_x = blink_phase && (edit_field selects x).
- Simultaneous pulse priority: reset > cd_zero expiry > btn_mode > btn_edit > btn_start. Lower-priority pulses in the same cycle are dropped.
- Reset mid-edit discards the edit; no load pulse is issued.

Optional Feature:
- Macro: CLOCK_MODE_EDIT_TIMEOUT_EN.
- When defined:
  - A counter in the edit states reloads on any button.
  - Reaching EDIT_TIMEOUT idle cycles cancels the edit exactly like btn_mode: no load, return to parent.
- When undefined: no counter; edits persist indefinitely; the EDIT_TIMEOUT parameter is unused.

Decomposition:
- Package clock_mode_pkg holds:
  - State enum.
  - Phase constants PH_USER=00, PH_CD=01, PH_CLK=10, PH_SW=11.
  - Field constants FLD_NONE/SEC/MIN/HOUR.
- Sub-module blink_prescaler (parameter BLINK_HALF; inputs clk, reset, restart; output blink_phase).
- Everything else stays in the controller FSM.

Test Plan:
- Reset, then 3 btn_mode pulses -> phase sequence 10, 01, 11, 10.
- In CLOCK: btn_edit x4 -> edit_field 01, 10, 11, then a single load_clk pulse and phase back to 10. With BLINK_HALF=4, blink_sec is high only in cycles 4-7 and 12-15 of the sec field.
- CD_IDLE with cd_zero=0, btn_start -> cd_run=1 next cycle. Raise cd_zero -> alarm=1 and cd_run=0 next cycle. With ALARM_CYCLES=10 and no buttons, alarm clears after 10 cycles and phase stays 01.
- In CD_RUN: btn_mode -> ignored, phase stays 01. Same cycle btn_mode+btn_edit in CLOCK -> mode wins, phase=01, no edit entry.
- In SW: btn_start -> sw_run=1. btn_edit -> no sw_clear. btn_start then btn_edit -> sw_clear single pulse. btn_mode with sw_run=1 -> sw_run still 1 in CLOCK.
- With CLOCK_MODE_EDIT_TIMEOUT_EN and EDIT_TIMEOUT=20: enter CD_EDIT, idle 20 cycles -> back to CD_IDLE, load_cd never asserted. Reset during CLK_EDIT -> state CLOCK, no load_clk.

Source files
------------

// File: rtl/clock_mode_pkg.sv
// rtl/clock_mode_pkg.sv - states, phase/field codes and phase decode for the clock mode controller
package clock_mode_pkg;

  typedef enum logic [2:0] {
    ST_CLOCK,
    ST_CLK_EDIT,
    ST_CD_IDLE,
    ST_CD_EDIT,
    ST_CD_RUN,
    ST_CD_ALARM,
    ST_SW
  } state_t;

  localparam logic [1:0] PH_USER = 2'b00;
  localparam logic [1:0] PH_CD   = 2'b01;
  localparam logic [1:0] PH_CLK  = 2'b10;
  localparam logic [1:0] PH_SW   = 2'b11;

  localparam logic [1:0] FLD_NONE = 2'b00;
  localparam logic [1:0] FLD_SEC  = 2'b01;
  localparam logic [1:0] FLD_MIN  = 2'b10;
  localparam logic [1:0] FLD_HOUR = 2'b11;

  function automatic logic [1:0] phase_of(input state_t s);
    logic [1:0] ph;
    case (s)
      ST_CLOCK:                          ph = PH_CLK;
      ST_CLK_EDIT, ST_CD_EDIT:           ph = PH_USER;
      ST_CD_IDLE, ST_CD_RUN, ST_CD_ALARM: ph = PH_CD;
      default:                           ph = PH_SW;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - free-running half-period counter producing the display blink phase
module blink_prescaler #(
  parameter int BLINK_HALF = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic blink_phase
);

  localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [CW-1:0] count;

  // restart realigns the period so a freshly selected field is shown first
  always_ff @(posedge clk) begin
    if (reset || restart) begin
      count       <= '0;
      blink_phase <= 1'b0;
    end else if (count == CW'(BLINK_HALF - 1)) begin
      count       <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/clock_mode_controller.sv
// rtl/clock_mode_controller.sv - mode/edit/run sequencer for the digital clock
// Optional edit idle auto-cancel: define CLOCK_MODE_EDIT_TIMEOUT_EN
module clock_mode_controller
  import clock_mode_pkg::*;
#(
  parameter int BLINK_HALF   = 25_000_000,
  parameter int ALARM_CYCLES = 500_000_000,
  parameter int EDIT_TIMEOUT = 1_000_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_edit,
  input  logic       btn_start,
  input  logic       cd_zero,
  output logic [1:0] phase,
  output logic [1:0] edit_field,
  output logic       blink_sec,
  output logic       blink_min,
  output logic       blink_hour,
  output logic       load_clk,
  output logic       load_cd,
  output logic       cd_run,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       alarm
);

  localparam int AW = $clog2(ALARM_CYCLES + 1);

  state_t     state, state_d;
  logic [1:0] field_d;
  logic       sw_run_d, load_clk_d, load_cd_d, sw_clear_d, restart;
  logic       bm, be, bs, any_btn;
  logic       alarm_done, timeout, blink_phase;
  logic [AW-1:0] alarm_cnt;

  // only the highest-priority button of a cycle is acted on
  assign bm      = btn_mode;
  assign be      = btn_edit & ~btn_mode;
  assign bs      = btn_start & ~btn_mode & ~btn_edit;
  assign any_btn = btn_mode | btn_edit | btn_start;

  assign alarm_done = (state == ST_CD_ALARM) && (alarm_cnt == AW'(ALARM_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || state != ST_CD_ALARM) alarm_cnt <= '0;
    else                               alarm_cnt <= alarm_cnt + 1'b1;
  end

`ifdef CLOCK_MODE_EDIT_TIMEOUT_EN
  localparam int TW = $clog2(EDIT_TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;
  logic          in_edit;

  assign in_edit = (state == ST_CLK_EDIT) || (state == ST_CD_EDIT);
  assign timeout = in_edit && !any_btn && (idle_cnt == TW'(EDIT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || !in_edit || any_btn) idle_cnt <= '0;
    else                              idle_cnt <= idle_cnt + 1'b1;
  end
`else
  // feature compiled out: constant low for any legal EDIT_TIMEOUT
  assign timeout = (EDIT_TIMEOUT < 0);
`endif

  always_comb begin
    state_d    = state;
    field_d    = edit_field;
    sw_run_d   = sw_run;
    load_clk_d = 1'b0;
    load_cd_d  = 1'b0;
    sw_clear_d = 1'b0;
    restart    = 1'b0;
    case (state)
      ST_CLOCK: begin
        if (bm) state_d = ST_CD_IDLE;
        else if (be) begin
          state_d = ST_CLK_EDIT;
          field_d = FLD_SEC;
          restart = 1'b1;
        end
      end
      ST_CD_IDLE: begin
        if (bm) state_d = ST_SW;
        else if (be) begin
          state_d = ST_CD_EDIT;
          field_d = FLD_SEC;
          restart = 1'b1;
        end else if (bs && !cd_zero) state_d = ST_CD_RUN;
      end
      ST_CD_RUN: begin
        if (cd_zero) state_d = ST_CD_ALARM;
        else if (bs) state_d = ST_CD_IDLE;
      end
      ST_CD_ALARM: begin
        if (any_btn || alarm_done) state_d = ST_CD_IDLE;
      end
      ST_SW: begin
        if (bm) state_d = ST_CLOCK;
        else if (be) sw_clear_d = ~sw_run;
        else if (bs) sw_run_d = ~sw_run;
      end
      ST_CLK_EDIT, ST_CD_EDIT: begin
        if (bm || timeout) begin
          state_d = (state == ST_CLK_EDIT) ? ST_CLOCK : ST_CD_IDLE;
          field_d = FLD_NONE;
        end else if (be) begin
          if (edit_field == FLD_HOUR) begin
            state_d    = (state == ST_CLK_EDIT) ? ST_CLOCK : ST_CD_IDLE;
            field_d    = FLD_NONE;
            load_clk_d = (state == ST_CLK_EDIT);
            load_cd_d  = (state == ST_CD_EDIT);
          end else begin
            field_d = edit_field + 2'd1;
          end
        end
      end
      default: state_d = ST_CLOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLOCK;
      phase      <= PH_CLK;
      edit_field <= FLD_NONE;
      load_clk   <= 1'b0;
      load_cd    <= 1'b0;
      cd_run     <= 1'b0;
      sw_run     <= 1'b0;
      sw_clear   <= 1'b0;
      alarm      <= 1'b0;
    end else begin
      state      <= state_d;
      phase      <= phase_of(state_d);
      edit_field <= field_d;
      load_clk   <= load_clk_d;
      load_cd    <= load_cd_d;
      cd_run     <= (state_d == ST_CD_RUN);
      sw_run     <= sw_run_d;
      sw_clear   <= sw_clear_d;
      alarm      <= (state_d == ST_CD_ALARM);
    end
  end

  blink_prescaler #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .clk        (clk),
    .reset      (reset),
    .restart    (restart),
    .blink_phase(blink_phase)
  );

  assign blink_sec  = blink_phase && (edit_field == FLD_SEC);
  assign blink_min  = blink_phase && (edit_field == FLD_MIN);
  assign blink_hour = blink_phase && (edit_field == FLD_HOUR);

endmodule

// File: tb/tb_clock_mode_controller.sv
// tb/tb_clock_mode_controller.sv - vector table, corner sequences and random run against a behavioural model
module tb_clock_mode_controller;

  localparam int BH = 4;
  localparam int AC = 10;
  localparam int ET = 20;
`ifdef CLOCK_MODE_EDIT_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [12:0] RESET_VEC = 13'b10_00_000_000000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0, btn_edit = 1'b0, btn_start = 1'b0, cd_zero = 1'b0;
  logic [1:0] phase, edit_field;
  logic blink_sec, blink_min, blink_hour, load_clk, load_cd, cd_run, sw_run, sw_clear, alarm;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  clock_mode_controller #(.BLINK_HALF(BH), .ALARM_CYCLES(AC), .EDIT_TIMEOUT(ET)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_edit(btn_edit), .btn_start(btn_start),
    .cd_zero(cd_zero), .phase(phase), .edit_field(edit_field), .blink_sec(blink_sec),
    .blink_min(blink_min), .blink_hour(blink_hour), .load_clk(load_clk), .load_cd(load_cd),
    .cd_run(cd_run), .sw_run(sw_run), .sw_clear(sw_clear), .alarm(alarm)
  );

  // model: mode 0 clock, 1 countdown, 2 stopwatch; editing/alarm are overlays on the mode
  int m_mode, m_field, m_alarm_age, m_edit_age, m_idle;
  bit m_edit, m_cdrun, m_alarm, m_swrun, e_lclk, e_lcd, e_swc;

  function automatic logic [12:0] dut_vec();
    return {phase, edit_field, blink_sec, blink_min, blink_hour,
            load_clk, load_cd, cd_run, sw_run, sw_clear, alarm};
  endfunction

  function automatic logic [12:0] model_vec();
    logic [1:0] ph;
    bit bl;
    ph = m_edit ? 2'b00 : (m_mode == 0) ? 2'b10 : (m_mode == 1) ? 2'b01 : 2'b11;
    bl = m_edit && (((m_edit_age / BH) % 2) == 1);
    return {ph, 2'(m_field), bl && m_field == 1, bl && m_field == 2, bl && m_field == 3,
            e_lclk, e_lcd, m_cdrun, m_swrun, e_swc, m_alarm};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_field = 0; m_alarm_age = 0; m_edit_age = 0; m_idle = 0;
    m_edit = 0; m_cdrun = 0; m_alarm = 0; m_swrun = 0; e_lclk = 0; e_lcd = 0; e_swc = 0;
  endtask

  task automatic enter_edit();
    m_edit = 1; m_field = 1; m_edit_age = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit m, input bit e, input bit s, input bit z);
    bit bm, be, bs, any, to;
    bm = m; be = e && !m; bs = s && !m && !e; any = m || e || s;
    e_lclk = 0; e_lcd = 0; e_swc = 0;
    if (m_edit) begin
      m_edit_age++;
      to = TO_EN && !any && (m_idle == ET - 1);
      m_idle = any ? 0 : m_idle + 1;
      if (bm || to) begin
        m_edit = 0; m_field = 0;
      end else if (be) begin
        if (m_field == 3) begin
          if (m_mode == 0) e_lclk = 1; else e_lcd = 1;
          m_edit = 0; m_field = 0;
        end else m_field++;
      end
    end else if (m_alarm) begin
      if (any || m_alarm_age == AC - 1) m_alarm = 0;
      else m_alarm_age++;
    end else if (m_mode == 0) begin
      if (bm) m_mode = 1;
      else if (be) enter_edit();
    end else if (m_mode == 1) begin
      if (m_cdrun) begin
        if (z) begin m_cdrun = 0; m_alarm = 1; m_alarm_age = 0; end
        else if (bs) m_cdrun = 0;
      end else if (bm) m_mode = 2;
      else if (be) enter_edit();
      else if (bs && !z) m_cdrun = 1;
    end else begin
      if (bm) m_mode = 0;
      else if (be) e_swc = !m_swrun;
      else if (bs) m_swrun = !m_swrun;
    end
  endtask

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step(input bit m, input bit e, input bit s, input string name);
    btn_mode = m; btn_edit = e; btn_start = s;
    @(posedge clk);
    if (reset) model_reset();
    else model_step(m, e, s, cd_zero);
    #1;
    btn_mode = 0; btn_edit = 0; btn_start = 0;
    check(name, dut_vec(), model_vec());
  endtask

  typedef struct {
    bit m, e, s, z;
    logic [12:0] exp;
  } vec_t;

  function automatic vec_t row(input bit m, input bit e, input bit s, input bit z,
                               input logic [1:0] ph, input logic [1:0] fld,
                               input bit lclk, input bit lcd, input bit cdr,
                               input bit swr, input bit swc, input bit alm);
    vec_t r;
    r.m = m; r.e = e; r.s = s; r.z = z;
    r.exp = {ph, fld, 3'b000, lclk, lcd, cdr, swr, swc, alm};
    return r;
  endfunction

  vec_t tbl[27];

  initial begin
    #1_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    bit m, e, s;
    tbl[0]  = row(1,0,0,0, 2'b01,2'b00, 0,0,0,0,0,0);
    tbl[1]  = row(1,0,0,0, 2'b11,2'b00, 0,0,0,0,0,0);
    tbl[2]  = row(1,0,0,0, 2'b10,2'b00, 0,0,0,0,0,0);
    tbl[3]  = row(0,1,0,0, 2'b00,2'b01, 0,0,0,0,0,0);
    tbl[4]  = row(0,1,0,0, 2'b00,2'b10, 0,0,0,0,0,0);
    tbl[5]  = row(0,1,0,0, 2'b00,2'b11, 0,0,0,0,0,0);
    tbl[6]  = row(0,1,0,0, 2'b10,2'b00, 1,0,0,0,0,0);
    tbl[7]  = row(0,0,0,0, 2'b10,2'b00, 0,0,0,0,0,0);
    tbl[8]  = row(1,1,0,0, 2'b01,2'b00, 0,0,0,0,0,0);
    tbl[9]  = row(0,0,1,0, 2'b01,2'b00, 0,0,1,0,0,0);
    tbl[10] = row(1,0,0,0, 2'b01,2'b00, 0,0,1,0,0,0);
    tbl[11] = row(0,0,0,1, 2'b01,2'b00, 0,0,0,0,0,1);
    tbl[12] = row(0,0,1,1, 2'b01,2'b00, 0,0,0,0,0,0);
    tbl[13] = row(0,0,1,1, 2'b01,2'b00, 0,0,0,0,0,0);
    tbl[14] = row(1,0,0,0, 2'b11,2'b00, 0,0,0,0,0,0);
    tbl[15] = row(0,0,1,0, 2'b11,2'b00, 0,0,0,1,0,0);
    tbl[16] = row(0,1,0,0, 2'b11,2'b00, 0,0,0,1,0,0);
    tbl[17] = row(0,0,1,0, 2'b11,2'b00, 0,0,0,0,0,0);
    tbl[18] = row(0,1,0,0, 2'b11,2'b00, 0,0,0,0,1,0);
    tbl[19] = row(0,0,0,0, 2'b11,2'b00, 0,0,0,0,0,0);
    tbl[20] = row(0,0,1,0, 2'b11,2'b00, 0,0,0,1,0,0);
    tbl[21] = row(1,0,0,0, 2'b10,2'b00, 0,0,0,1,0,0);
    tbl[22] = row(1,0,0,0, 2'b01,2'b00, 0,0,0,1,0,0);
    tbl[23] = row(0,1,0,0, 2'b00,2'b01, 0,0,0,1,0,0);
    tbl[24] = row(1,0,0,0, 2'b01,2'b00, 0,0,0,1,0,0);
    tbl[25] = row(1,0,0,0, 2'b11,2'b00, 0,0,0,1,0,0);
    tbl[26] = row(0,0,1,0, 2'b11,2'b00, 0,0,0,0,0,0);

    reset = 1;
    step(0, 0, 0, "reset_model");
    check("reset_state", dut_vec(), RESET_VEC);
    reset = 0;

    for (int i = 0; i < 27; i++) begin
      cd_zero = tbl[i].z;
      step(tbl[i].m, tbl[i].e, tbl[i].s, $sformatf("model_row%0d", i));
      check($sformatf("table_row%0d", i), dut_vec(), tbl[i].exp);
    end
    cd_zero = 0;

    // blink_sec shows cycles 4-7 and 12-15 after entering the sec field
    step(1, 0, 0, "to_clock");
    step(0, 1, 0, "blink_entry");
    check("blink_sec_c0", {12'b0, blink_sec}, 13'd0);
    for (int k = 1; k < 16; k++) begin
      step(0, 0, 0, "blink_idle");
      check($sformatf("blink_sec_c%0d", k), {12'b0, blink_sec},
            {12'b0, ((k >= 4 && k < 8) || k >= 12) ? 1'b1 : 1'b0});
    end
    step(1, 0, 0, "blink_cancel");
    check("cancel_no_load", {11'b0, load_clk, load_cd}, 13'd0);

    // countdown run, expiry and alarm auto-clear after AC cycles
    step(1, 0, 0, "to_cd");
    step(0, 0, 1, "cd_start");
    check("cd_run_on", {12'b0, cd_run}, 13'd1);
    cd_zero = 1;
    step(0, 0, 0, "cd_expire");
    check("expire_alarm", {11'b0, alarm, cd_run}, 13'b10);
    for (int k = 1; k <= AC; k++) begin
      step(0, 0, 0, "alarm_idle");
      check($sformatf("alarm_c%0d", k), {10'b0, phase, alarm}, {10'b0, 2'b01, (k < AC) ? 1'b1 : 1'b0});
    end
    cd_zero = 0;

    // long idle in CD_EDIT: auto-cancel only with the timeout build
    step(0, 1, 0, "cd_edit_enter");
    for (int k = 1; k <= ET + 5; k++) begin
      step(0, 0, 0, "cd_edit_idle");
      check($sformatf("edit_idle_c%0d", k), {10'b0, phase, load_cd},
            {10'b0, (TO_EN && k >= ET) ? 2'b01 : 2'b00, 1'b0});
    end

    // reset in the middle of a clock edit
    reset = 1;
    step(0, 0, 0, "reset2");
    reset = 0;
    step(0, 1, 0, "clk_edit_enter");
    step(0, 1, 0, "clk_edit_min");
    reset = 1;
    step(0, 0, 0, "reset_mid_edit");
    check("reset_mid_edit_state", dut_vec(), RESET_VEC);
    reset = 0;
    step(0, 0, 0, "after_reset");
    check("after_reset_no_load", {12'b0, load_clk}, 13'd0);

    for (int n = 0; n < 3000; n++) begin
      m = ($urandom_range(0, 11) == 0);
      e = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 9) == 0) cd_zero = ~cd_zero;
      reset = ($urandom_range(0, 399) == 0);
      step(m, e, s, $sformatf("random_%0d", n));
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
